// File: rtl/user_input_bank.sv
// user_input_bank: a bank of independent push-button channels.
// Each channel synchronizes its raw level, debounces it into "held",
// emits a one-cycle "pressed" pulse on every accepted press, and can
// auto-repeat that pulse while the button stays down.
//
// Repeat FSM states:
//   state     | meaning
//   ST_IDLE   | no press being timed; waiting for held to rise
//   ST_DELAY  | press accepted, counting the initial hold-off before repeats
//   ST_REPEAT | repeating; one pulse every REPEAT_RATE cycles
module user_input_bank #(
  parameter int CHANNELS     = 4,
  parameter int DEBOUNCE     = 3,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] held,
  output logic [CHANNELS-1:0] pressed
);

  // Debounce counter only needs to reach DEBOUNCE-1 before it clears.
  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  // One repeat counter serves both the hold-off and the repeat interval.
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RR_LAST = RPT_W'(REPEAT_RATE - 1);
  localparam logic [RPT_W-1:0] RPT_ONE = RPT_W'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [CHANNELS-1:0]            s1;
  logic [CHANNELS-1:0]            s2;
  logic [CHANNELS-1:0][DB_W-1:0]  db_cnt;
  logic [CHANNELS-1:0][DB_W-1:0]  db_cnt_nxt;
  logic [CHANNELS-1:0]            flip;
  logic [CHANNELS-1:0]            rise;
  logic [CHANNELS-1:0][1:0]       state;
  logic [CHANNELS-1:0][1:0]       state_nxt;
  logic [CHANNELS-1:0][RPT_W-1:0] rpt_cnt;
  logic [CHANNELS-1:0][RPT_W-1:0] rpt_cnt_nxt;
  logic [CHANNELS-1:0]            rpt_pulse;

  // Two-flop synchronizer on the raw button levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in;
      s2 <= s1;
    end
  end

  // Debounce: count consecutive cycles where the synchronized level
  // disagrees with held; flip held once the disagreement lasts DEBOUNCE cycles.
  always_comb begin
    flip       = '0;
    db_cnt_nxt = db_cnt;
    for (int i = 0; i < CHANNELS; i++) begin
      if (s2[i] == held[i]) begin
        db_cnt_nxt[i] = '0;
      end else if (db_cnt[i] == DB_LAST) begin
        flip[i]       = 1'b1;
        db_cnt_nxt[i] = '0;
      end else begin
        db_cnt_nxt[i] = db_cnt[i] + DB_ONE;
      end
    end
  end

  // A press is only the 0->1 direction of a held flip.
  assign rise = flip & ~held;

  // Repeat FSM next-state and repeat-pulse generation per channel.
  // A fresh press always restarts the hold-off, even if the FSM has not yet
  // noticed the previous release (possible with very short debounce).
  always_comb begin
    state_nxt   = state;
    rpt_cnt_nxt = rpt_cnt;
    rpt_pulse   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rise[i]) begin
        state_nxt[i]   = ST_DELAY;
        rpt_cnt_nxt[i] = '0;
      end else begin
        case (state[i])
          ST_IDLE: begin
            rpt_cnt_nxt[i] = '0;
          end
          ST_DELAY: begin
            if (!held[i] || !repeat_en[i]) begin
              state_nxt[i]   = ST_IDLE;
              rpt_cnt_nxt[i] = '0;
            end else if (rpt_cnt[i] == RD_LAST) begin
              rpt_pulse[i]   = 1'b1;
              state_nxt[i]   = ST_REPEAT;
              rpt_cnt_nxt[i] = '0;
            end else begin
              rpt_cnt_nxt[i] = rpt_cnt[i] + RPT_ONE;
            end
          end
          ST_REPEAT: begin
            if (!held[i] || !repeat_en[i]) begin
              state_nxt[i]   = ST_IDLE;
              rpt_cnt_nxt[i] = '0;
            end else if (rpt_cnt[i] == RR_LAST) begin
              rpt_pulse[i]   = 1'b1;
              rpt_cnt_nxt[i] = '0;
            end else begin
              rpt_cnt_nxt[i] = rpt_cnt[i] + RPT_ONE;
            end
          end
          default: begin
            state_nxt[i]   = ST_IDLE;
            rpt_cnt_nxt[i] = '0;
          end
        endcase
      end
    end
  end

  // Register debounce, FSM and output state; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt  <= '0;
      held    <= '0;
      pressed <= '0;
      state   <= '0;
      rpt_cnt <= '0;
    end else begin
      db_cnt  <= db_cnt_nxt;
      held    <= held ^ flip;
      pressed <= rise | rpt_pulse;
      state   <= state_nxt;
      rpt_cnt <= rpt_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_user_input_bank.sv
// Directed bench for user_input_bank with default parameters.
// Expected pressed pulses are queued as (edge number, channel mask) when a
// stimulus step is applied; a monitor compares pressed every cycle against
// the queue head, so both missing and spurious pulses are caught.
module tb_user_input_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in;
  logic [3:0] repeat_en;
  logic [3:0] held;
  logic [3:0] pressed;

  typedef struct {
    int         edge_n;
    logic [3:0] mask;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  int   c0;

  user_input_bank #(
    .CHANNELS(4), .DEBOUNCE(3), .REPEAT_DELAY(8), .REPEAT_RATE(4)
  ) dut (
    .clk(clk), .reset(reset), .in(in), .repeat_en(repeat_en),
    .held(held), .pressed(pressed)
  );

  always #5 clk = ~clk;

  // Edge counter: cyc equals the number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: pressed at each falling edge must match the queue head.
  always @(negedge clk) begin
    logic [3:0] exp_p;
    exp_p = 4'b0000;
    if (sb.size() > 0 && sb[0].edge_n == cyc) begin
      exp_p = sb[0].mask;
      void'(sb.pop_front());
    end
    tests++;
    assert (pressed === exp_p) else begin
      fails++;
      $error("FAIL pressed at edge %0d: got %b expected %b", cyc, pressed, exp_p);
    end
  end

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s at edge %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    in        = 4'b0000;
    repeat_en = 4'b0000;
    tick(3);
    chk("reset_held", held, 4'b0000);
    chk("reset_pressed", pressed, 4'b0000);
    reset = 1'b0;
    tick(2);

    // Clean press on ch0, no repeat: one pulse 5 edges after the step.
    c0 = cyc;
    in = 4'b0001;
    sb.push_back('{c0 + 5, 4'b0001});
    tick(4);
    chk("clean_before", held, 4'b0000);
    tick(1);
    chk("clean_held", held, 4'b0001);
    tick(5);
    in = 4'b0000;
    tick(4);
    chk("clean_hold_on", held, 4'b0001);
    tick(1);
    chk("clean_release", held, 4'b0000);
    tick(5);

    // Glitch on ch1 shorter than DEBOUNCE: nothing happens.
    in = 4'b0010;
    tick(2);
    in = 4'b0000;
    tick(10);
    chk("glitch_held", held, 4'b0000);

    // Glitch of exactly DEBOUNCE-1 = 2 cycles followed by another short one.
    in = 4'b0010;
    tick(2);
    in = 4'b0000;
    tick(1);
    in = 4'b0010;
    tick(2);
    in = 4'b0000;
    tick(10);
    chk("glitch2_held", held, 4'b0000);

    // Auto-repeat on ch2, held 30 cycles: P, P+8, then every 4.
    c0        = cyc;
    repeat_en = 4'b0100;
    in        = 4'b0100;
    sb.push_back('{c0 + 5, 4'b0100});
    for (int k = c0 + 13; k <= c0 + 33; k += 4) sb.push_back('{k, 4'b0100});
    tick(30);
    in = 4'b0000;
    tick(4);
    chk("repeat_hold_on", held, 4'b0100);
    tick(1);
    chk("repeat_release", held, 4'b0000);
    tick(10);
    repeat_en = 4'b0000;

    // Simultaneous press on channels 0, 1 and 3.
    c0 = cyc;
    in = 4'b1011;
    sb.push_back('{c0 + 5, 4'b1011});
    tick(4);
    chk("simul_before", held, 4'b0000);
    tick(1);
    chk("simul_held", held, 4'b1011);
    tick(3);
    in = 4'b0000;
    tick(10);
    chk("simul_release", held, 4'b0000);

    // Reset pulse while ch2 is repeating; press is re-debounced afterwards.
    c0        = cyc;
    repeat_en = 4'b0100;
    in        = 4'b0100;
    sb.push_back('{c0 + 5, 4'b0100});
    sb.push_back('{c0 + 13, 4'b0100});
    sb.push_back('{c0 + 17, 4'b0100});
    sb.push_back('{c0 + 25, 4'b0100});
    tick(19);
    chk("pre_reset_held", held, 4'b0100);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("reset_mid_held", held, 4'b0000);
    chk("reset_mid_pressed", pressed, 4'b0000);
    tick(4);
    chk("after_reset_before", held, 4'b0000);
    tick(1);
    chk("after_reset_held", held, 4'b0100);
    tick(1);
    repeat_en = 4'b0000;
    tick(12);
    chk("no_repeat_held", held, 4'b0100);
    in = 4'b0000;
    tick(10);
    chk("final_held", held, 4'b0000);

    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_empty: got %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/user_input_bank.md
USER_INPUT_BANK -- requirements
Module: user_input_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4; number of independent button channels (1..32).
REQ-002 SHALL have parameter DEBOUNCE, default 3; consecutive stable cycles required to accept a level change (>=1).
REQ-003 SHALL have parameter REPEAT_DELAY, default 8; cycles a press must be held before the first repeat pulse (>=1).
REQ-004 SHALL have parameter REPEAT_RATE, default 4; cycles between subsequent repeat pulses (>=1).
REQ-005 SHALL have port clk, input, 1; single clock, all state on the rising edge.
REQ-006 SHALL have port reset, input, 1; synchronous, active-high reset.
REQ-007 SHALL have port in, input, CHANNELS; raw asynchronous button levels, 1 = pressed.
REQ-008 SHALL have port repeat_en, input, CHANNELS; per-channel auto-repeat enable, sampled every cycle.
REQ-009 SHALL have port held, output reg, CHANNELS; debounced button level.
REQ-010 SHALL have port pressed, output reg, CHANNELS; one-cycle press pulse per accepted press or repeat.

Function
REQ-011 SHALL pass each in bit through a two-flop synchronizer (s1, s2) before any other logic.
REQ-012 SHALL keep a per-channel debounce counter: it increments while s2 != held and clears to 0 on any cycle where s2 == held.
REQ-013 SHALL toggle held[i] and clear its counter on the edge where the counter equals DEBOUNCE-1 and s2 still differs; so a clean step on in appears on held DEBOUNCE+2 edges after the first edge that samples it.
REQ-014 SHALL reject any in pulse or glitch shorter than DEBOUNCE cycles at s2; held is unchanged.
REQ-015 SHALL assert pressed[i] for exactly one cycle, on the same edge where held[i] goes 0->1; held 1->0 never pulses.
REQ-016 SHALL run a per-channel repeat FSM with states IDLE, DELAY and REPEAT, plus a repeat counter sized for max(REPEAT_DELAY, REPEAT_RATE).
REQ-017 IDLE: on held 0->1, go to DELAY with counter = 0.
REQ-018 DELAY: increment counter each cycle; when counter reaches REPEAT_DELAY-1 with held=1 and repeat_en[i]=1, pulse pressed[i], go to REPEAT, and clear counter.
REQ-019 REPEAT: increment counter each cycle; when it reaches REPEAT_RATE-1, pulse pressed[i] and clear counter; stay in REPEAT.
REQ-020 In DELAY or REPEAT, held[i]=0 or repeat_en[i]=0 SHALL return the FSM to IDLE next edge with no pulse; the counter clears.
REQ-021 The initial-press pulse and a repeat pulse can never coincide: the first repeat pulse is at least REPEAT_DELAY cycles after the press pulse.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
REQ-023 All counters SHALL saturate or clear as specified and never wrap to produce a spurious pulse.

Reset
REQ-024 reset=1 at a clock edge SHALL clear s1, s2, held, pressed, all counters and all FSMs to IDLE, overriding all other activity.
REQ-025 Reset mid-press SHALL NOT generate a pulse. After release, a still-asserted in is re-debounced and produces one fresh press pulse DEBOUNCE+2 edges after reset deasserts.

Verification
REQ-026 Clean press: CHANNELS=4, defaults, in[0] 0->1 held 10 cycles, repeat_en=0 -> held[0]=1 at edge 5 after the step, one pressed[0] pulse there, no further pulses.
REQ-027 Glitch: in[1]=1 for 2 cycles, then 0 -> held[1] and pressed[1] stay 0 throughout.
REQ-028 Auto-repeat: repeat_en[2]=1, in[2] held 30 cycles -> pulses at press edge P, P+8, P+12, P+16, ...; release stops pulses within 1 cycle after held falls.
REQ-029 Simultaneous press: in=4'b1011 in one step -> held and pressed pulse on channels 0, 1 and 3 on the same edge; channel 2 stays 0.
REQ-030 Reset mid-operation: reset pulsed for 1 cycle during REPEAT on ch2 with in[2] still 1 -> all outputs 0 next edge; held[2] and a single pressed[2] return 5 edges after reset deasserts.
